// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined block carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 forms bit and 4-bit group generate/propagate; stage 2 resolves carries and flags.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / GROUP;

    generate
        if (GROUP != 4) begin : g_group_chk
            $error("cla_pipe_adder: GROUP must be 4");
        end
        if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_width_chk
            $error("cla_pipe_adder: WIDTH must be a multiple of 4 in 4..64");
        end
    endgenerate

    logic s2_en;
    logic s1_en;
    logic s1_valid_q;
    logic out_valid_q;

    assign s2_en    = ~out_valid_q | out_ready;
    assign s1_en    = ~s1_valid_q | s2_en;
    assign in_ready = s1_en;

    // Stage 1: subtraction is A + ~B + 1, so only B and the carry-in are conditioned.
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] p_d, g_d;
    logic [NG-1:0]    gg_d, gp_d;
    logic             c0_d;

    assign bb   = sub ? ~b : b;
    assign c0_d = sub | cin;
    assign p_d  = a ^ bb;
    assign g_d  = a & bb;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp1
            localparam int B = gi * 4;
            assign gg_d[gi] = g_d[B+3]
                            | (p_d[B+3] & g_d[B+2])
                            | (p_d[B+3] & p_d[B+2] & g_d[B+1])
                            | (p_d[B+3] & p_d[B+2] & p_d[B+1] & g_d[B]);
            assign gp_d[gi] = &p_d[B+3:B];
        end
    endgenerate

    logic [WIDTH-1:0] p_q, g_q;
    logic [NG-1:0]    gg_q, gp_q;
    logic             c0_q, a_msb_q, bb_msb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            g_q        <= '0;
            gg_q       <= '0;
            gp_q       <= '0;
            c0_q       <= 1'b0;
            a_msb_q    <= 1'b0;
            bb_msb_q   <= 1'b0;
        end else if (s1_en) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                p_q      <= p_d;
                g_q      <= g_d;
                gg_q     <= gg_d;
                gp_q     <= gp_d;
                c0_q     <= c0_d;
                a_msb_q  <= a[WIDTH-1];
                bb_msb_q <= bb[WIDTH-1];
            end
        end
    end

    // Second-level lookahead: each group carry is a flat sum of products over GG/GP/c0.
    logic [NG:0] gc;

    always_comb begin
        logic acc;
        logic term;
        gc    = '0;
        acc   = 1'b0;
        term  = 1'b0;
        gc[0] = c0_q;
        for (int k = 1; k <= NG; k++) begin
            acc = c0_q;
            for (int i = 0; i < k; i++) acc = acc & gp_q[i];
            for (int j = 0; j < k; j++) begin
                term = gg_q[j];
                for (int i = j + 1; i < k; i++) term = term & gp_q[i];
                acc = acc | term;
            end
            gc[k] = acc;
        end
    end

    logic [WIDTH-1:0] carry_vec;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d, ovf_d, zero_d;

    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp2
            localparam int B = gi * 4;
            assign carry_vec[B]   = gc[gi];
            assign carry_vec[B+1] = g_q[B] | (p_q[B] & gc[gi]);
            assign carry_vec[B+2] = g_q[B+1] | (p_q[B+1] & g_q[B])
                                  | (p_q[B+1] & p_q[B] & gc[gi]);
            assign carry_vec[B+3] = g_q[B+2] | (p_q[B+2] & g_q[B+1])
                                  | (p_q[B+2] & p_q[B+1] & g_q[B])
                                  | (p_q[B+2] & p_q[B+1] & p_q[B] & gc[gi]);
        end
    endgenerate

    assign sum_d  = p_q ^ carry_vec;
    assign cout_d = gc[NG];
    assign ovf_d  = (a_msb_q == bb_msb_q) && (sum_d[WIDTH-1] != a_msb_q);
    assign zero_d = ~|sum_d;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b1;
        end else if (s2_en) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: drivers push model results, one monitor pops and compares.
// Covers WIDTH=16 directed/stall/reset/random traffic plus WIDTH=4 and WIDTH=64 random sweeps.
module tb_cla_pipe_adder;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // WIDTH=16 DUT
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0, sub = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout, ovf, zero;

    cla_pipe_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    // WIDTH=4 and WIDTH=64 DUTs share control inputs
    logic        rst_n_x = 1'b0;
    logic        in_valid_x = 1'b0, cin_x = 1'b0, sub_x = 1'b0, out_ready_x = 1'b1;
    logic [3:0]  a4 = '0, b4 = '0, s4;
    logic [63:0] a64 = '0, b64 = '0, s64;
    logic        rdy4, ov4, co4, of4, z4;
    logic        rdy64, ov64, co64, of64, z64;

    cla_pipe_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n_x), .in_valid(in_valid_x), .in_ready(rdy4),
        .a(a4), .b(b4), .cin(cin_x), .sub(sub_x), .out_valid(ov4), .out_ready(out_ready_x),
        .sum(s4), .cout(co4), .ovf(of4), .zero(z4)
    );

    cla_pipe_adder #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n_x), .in_valid(in_valid_x), .in_ready(rdy64),
        .a(a64), .b(b64), .cin(cin_x), .sub(sub_x), .out_valid(ov64), .out_ready(out_ready_x),
        .sum(s64), .cout(co64), .ovf(of64), .zero(z64)
    );

    exp_t q[$];
    exp_t q4[$];
    exp_t q64[$];
    bit   front_seen = 1'b0;
    bit   xdone = 1'b0;
    bit   rdone = 1'b0;

    // Reference: plain modular arithmetic and signed-range reasoning.
    function automatic exp_t model(input int w, input logic [63:0] xa, input logic [63:0] xb,
                                   input logic xc, input logic xs);
        exp_t        e;
        logic [64:0] mask, aa, bx, full, s;
        logic        sa, sb, ss;
        mask = (65'd1 << w) - 65'd1;
        aa   = {1'b0, xa} & mask;
        bx   = {1'b0, xb} & mask;
        if (!xs) begin
            full   = aa + bx + 65'(xc);
            e.cout = full[w];
        end else begin
            full   = aa - bx;
            e.cout = (aa >= bx);
        end
        s      = full & mask;
        sa     = aa[w-1];
        sb     = bx[w-1];
        ss     = s[w-1];
        e.ovf  = xs ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        e.sum  = s[63:0];
        e.zero = (s == 65'd0);
        e.lat  = -1;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sole owner of the counters
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                front_seen = 1'b0;
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_sum",       64'(sum),       64'd0);
                chk("rst_cout",      64'(cout),      64'd0);
                chk("rst_ovf",       64'(ovf),       64'd0);
                chk("rst_zero",      64'(zero),      64'd1);
                chk("rst_in_ready",  64'(in_ready),  64'd1);
            end else begin
                chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
                if (q.size() == 0) begin
                    chk("idle_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    e = q[0];
                    if (e.lat >= 0 && !front_seen)
                        chk("latency_out_valid", 64'(out_valid), 64'(cyc >= e.lat));
                    if (out_valid) begin
                        front_seen = 1'b1;
                        chk("sum",  64'(sum),  e.sum);
                        chk("cout", 64'(cout), 64'(e.cout));
                        chk("ovf",  64'(ovf),  64'(e.ovf));
                        chk("zero", 64'(zero), 64'(e.zero));
                        if (out_ready) begin
                            void'(q.pop_front());
                            front_seen = 1'b0;
                            $display("beat w16 sum=%h cout=%b ovf=%b zero=%b", sum, cout, ovf, zero);
                        end
                    end
                end
            end
            if (rst_n_x) begin
                if (q4.size() == 0) begin
                    chk("w4_idle_out_valid", 64'(ov4), 64'd0);
                end else if (ov4) begin
                    e = q4.pop_front();
                    chk("w4_sum",  64'(s4),  e.sum);
                    chk("w4_cout", 64'(co4), 64'(e.cout));
                    chk("w4_ovf",  64'(of4), 64'(e.ovf));
                    chk("w4_zero", 64'(z4),  64'(e.zero));
                    $display("beat w4 sum=%h cout=%b ovf=%b zero=%b", s4, co4, of4, z4);
                end
                if (q64.size() == 0) begin
                    chk("w64_idle_out_valid", 64'(ov64), 64'd0);
                end else if (ov64) begin
                    e = q64.pop_front();
                    chk("w64_sum",  s64,          e.sum);
                    chk("w64_cout", 64'(co64),    64'(e.cout));
                    chk("w64_ovf",  64'(of64),    64'(e.ovf));
                    chk("w64_zero", 64'(z64),     64'(e.zero));
                    $display("beat w64 sum=%h cout=%b ovf=%b zero=%b", s64, co64, of64, z64);
                end
            end
        end
    end

    // Present one beat at posedge+1 and hold it until accepted; lc requests a latency check.
    task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                        input logic xs, input bit lc);
        exp_t e;
        bit   rdy;
        int   n;
        n = 0;
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
        e = model(16, 64'(xa), 64'(xb), xc, xs);
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                $display("FAIL send_accept: got no accept expected accept within 200 cycles");
                $fatal(1, "accept timeout");
            end
        end while (!rdy);
        e.lat = lc ? cyc + 1 : -1;
        q.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 || q4.size() != 0 || q64.size() != 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 300) begin
                $display("FAIL drain: got %0d beats pending expected 0", q.size() + q4.size() + q64.size());
                $fatal(1, "drain timeout");
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Wide/narrow random sweep, out_ready tied high
    initial begin
        bit r4, r64;
        repeat (4) @(posedge clk);
        #1 rst_n_x = 1'b1;
        for (int i = 0; i < 200; i++) begin
            a4    = 4'($urandom);
            b4    = 4'($urandom);
            a64   = {$urandom, $urandom};
            b64   = {$urandom, $urandom};
            cin_x = 1'($urandom);
            sub_x = 1'($urandom);
            if (i == 0) begin
                a4 = 4'hF; b4 = 4'h1; a64 = '1; b64 = 64'd1; sub_x = 1'b0; cin_x = 1'b0;
            end else if (i == 1) begin
                a4 = 4'h8; b4 = 4'h1; a64 = 64'h8000_0000_0000_0000; b64 = 64'd1; sub_x = 1'b1;
            end else if (i == 2) begin
                b4 = a4; b64 = a64; sub_x = 1'b1;
            end
            in_valid_x = 1'b1;
            @(negedge clk);
            r4  = rdy4;
            r64 = rdy64;
            @(posedge clk);
            #1;
            if (r4)  q4.push_back(model(4, 64'(a4), 64'(b4), cin_x, sub_x));
            if (r64) q64.push_back(model(64, a64, b64, cin_x, sub_x));
        end
        in_valid_x = 1'b0;
        xdone = 1'b1;
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1); drain();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1); drain();
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1); drain();
        send(16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1); drain();
        send(16'h0003, 16'h0005, 1'b1, 1'b1, 1'b1); drain();
        send(16'h1234, 16'h1234, 1'b1, 1'b1, 1'b1); drain();

        for (int i = 0; i < 8; i++) send(16'(i), 16'(3 * i), 1'b0, 1'b0, 1'b1);
        drain();

        fork
            begin
                for (int i = 0; i < 10; i++) send(16'(100 + i), 16'(7 * i), 1'b0, 1'b0, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset while two beats occupy both stages; neither may emerge afterwards
        send(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
        send(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(3, 0) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(2, 0) != 0);
                end
            end
        join
        out_ready = 1'b1;

        n = 0;
        while (!xdone) begin
            @(posedge clk);
            n++;
            if (n > 2000) begin
                $display("FAIL sweep_done: got not done expected done within 2000 cycles");
                $fatal(1, "sweep timeout");
            end
        end
        #1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
